// File: rtl/mem_stage_lsu_pkg.sv
// mem_stage_lsu shared types
// op codes, states and data-path helpers
package mem_stage_lsu_pkg;

  localparam logic [2:0] DM_LB  = 3'b000;
  localparam logic [2:0] DM_LH  = 3'b001;
  localparam logic [2:0] DM_LW  = 3'b010;
  localparam logic [2:0] DM_LBU = 3'b100;
  localparam logic [2:0] DM_LHU = 3'b101;

  localparam logic [3:0] AMO_LR   = 4'd0;
  localparam logic [3:0] AMO_SC   = 4'd1;
  localparam logic [3:0] AMO_SWAP = 4'd2;
  localparam logic [3:0] AMO_ADD  = 4'd3;
  localparam logic [3:0] AMO_XOR  = 4'd4;
  localparam logic [3:0] AMO_AND  = 4'd5;
  localparam logic [3:0] AMO_OR   = 4'd6;
  localparam logic [3:0] AMO_MIN  = 4'd7;
  localparam logic [3:0] AMO_MAX  = 4'd8;
  localparam logic [3:0] AMO_MINU = 4'd9;
  localparam logic [3:0] AMO_MAXU = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_AMO_WR,
    S_DONE
  } lsu_state_e;

  typedef enum logic [2:0] {
    K_LOAD,
    K_STORE,
    K_LR,
    K_SC,
    K_AMO
  } lsu_kind_e;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } lsu_size_e;

  typedef struct packed {
    lsu_kind_e   kind;
    logic [2:0]  sel;
    logic [1:0]  off;
    logic [3:0]  aop;
    logic [31:0] opb;
    logic [29:0] word;
  } lsu_ctx_t;

  function automatic lsu_size_e st_size(
    input logic [3:0] we
  );
    lsu_size_e sz;
    unique case (we)
      4'b0001, 4'b0010,
      4'b0100, 4'b1000: sz = SZ_B;
      4'b0011, 4'b1100: sz = SZ_H;
      default:          sz = SZ_W;
    endcase
    return sz;
  endfunction

  function automatic lsu_size_e ld_size(
    input logic [2:0] sel
  );
    lsu_size_e sz;
    unique case (sel)
      DM_LB, DM_LBU: sz = SZ_B;
      DM_LH, DM_LHU: sz = SZ_H;
      default:       sz = SZ_W;
    endcase
    return sz;
  endfunction

  function automatic logic [31:0] st_rep(
    input logic [31:0] d,
    input lsu_size_e   sz
  );
    logic [31:0] r;
    unique case (sz)
      SZ_B:    r = {4{d[7:0]}};
      SZ_H:    r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] ld_align(
    input logic [31:0] w,
    input logic [1:0]  off,
    input logic [2:0]  sel
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    unique case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    unique case (sel)
      DM_LB:   r = {{24{b[7]}}, b};
      DM_LH:   r = {{16{h[15]}}, h};
      DM_LBU:  r = {24'd0, b};
      DM_LHU:  r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_amo_alu.sv
// mem_stage_lsu AMO modify step
// old word and rs2 in, word to write back out
import mem_stage_lsu_pkg::*;

module amo_alu (
  input  logic [31:0] old,
  input  logic [31:0] opb,
  input  logic [3:0]  op,
  output logic [31:0] res
);

  logic lt_s;
  logic lt_u;

  assign lt_s = $signed(old) < $signed(opb);
  assign lt_u = old < opb;

  // read-modify function select
  always_comb begin
    res = opb;
    unique case (op)
      AMO_SWAP: res = opb;
      AMO_ADD:  res = old + opb;
      AMO_XOR:  res = old ^ opb;
      AMO_AND:  res = old & opb;
      AMO_OR:   res = old | opb;
      AMO_MIN:  res = lt_s ? old : opb;
      AMO_MAX:  res = lt_s ? opb : old;
      AMO_MINU: res = lt_u ? old : opb;
      AMO_MAXU: res = lt_u ? opb : old;
      default:  res = opb;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store/atomic unit
// one cache access in flight, LR/SC reservation
import mem_stage_lsu_pkg::*;

module mem_stage_lsu #(
  parameter int WORD_W  = 32,
  parameter int RESV_EN = 1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [WORD_W-1:0] mem_ALUout,
  input  logic [WORD_W-1:0] mem_storedata,
  input  logic [WORD_W-1:0] mem_opB,
  input  logic [3:0]        mem_dm_write,
  input  logic [2:0]        mem_dm_select,
  input  logic              mem_is_ltype,
  input  logic              mem_is_stype,
  input  logic              mem_is_atomic,
  input  logic [3:0]        mem_atomic_op,
  input  logic              mem_to_OCM,
  output logic              dc_req,
  output logic [3:0]        dc_we,
  output logic [WORD_W-1:0] dc_addr,
  output logic [WORD_W-1:0] dc_wdata,
  input  logic              dc_ack,
  input  logic [WORD_W-1:0] dc_rdata,
  output logic [WORD_W-1:0] mem_loaddata,
  output logic              mem_load_valid,
  output logic              stall_mem,
  output logic              misaligned
);

  lsu_state_e  state, state_d;
  lsu_ctx_t    ctx, ctx_d, ctx_in;
  lsu_kind_e   kind_in;
  lsu_size_e   acc_sz;
  logic        req_d;
  logic [3:0]  we_d;
  logic [31:0] addr_d;
  logic [31:0] wdata_d;
  logic [31:0] ld_d;
  logic        resv_valid, rv_d;
  logic [29:0] resv_addr, ra_d;
  logic [31:0] amo_res;
  logic        any_mem;
  logic        mis_raw;
  logic        op;
  logic        hit;
  logic        stall_c;

  amo_alu u_amo (
    .old (dc_rdata),
    .opb (ctx.opb),
    .op  (ctx.aop),
    .res (amo_res)
  );

  assign any_mem = mem_is_ltype
                 | mem_is_stype
                 | mem_is_atomic;

  // access width for the alignment check
  always_comb begin
    acc_sz = SZ_W;
    unique case (1'b1)
      mem_is_atomic: acc_sz = SZ_W;
      mem_is_stype:  acc_sz = st_size(mem_dm_write);
      mem_is_ltype:  acc_sz = ld_size(mem_dm_select);
      default:       acc_sz = SZ_W;
    endcase
  end

  assign mis_raw = any_mem & (
      ((acc_sz == SZ_H) & mem_ALUout[0])
    | ((acc_sz == SZ_W) & (|mem_ALUout[1:0])));

  assign misaligned = nrst & mis_raw;
  assign op = any_mem & ~mem_to_OCM & ~mis_raw;

  // classify the instruction sitting in MEM
  always_comb begin
    kind_in = K_LOAD;
    unique case (1'b1)
      mem_is_atomic: begin
        if (mem_atomic_op == AMO_LR)
          kind_in = K_LR;
        else if (mem_atomic_op == AMO_SC)
          kind_in = K_SC;
        else
          kind_in = K_AMO;
      end
      mem_is_stype: kind_in = K_STORE;
      default:      kind_in = K_LOAD;
    endcase
  end

  assign ctx_in = '{
    kind: kind_in,
    sel:  mem_dm_select,
    off:  mem_ALUout[1:0],
    aop:  mem_atomic_op,
    opb:  mem_opB,
    word: mem_ALUout[31:2]
  };

  assign hit = (RESV_EN != 0) & resv_valid
             & (resv_addr == mem_ALUout[31:2]);

  assign stall_mem = nrst & stall_c;
  assign mem_load_valid = (state == S_DONE);

  // next state, cache request and result
  always_comb begin
    state_d = state;
    ctx_d   = ctx;
    req_d   = dc_req;
    we_d    = dc_we;
    addr_d  = dc_addr;
    wdata_d = dc_wdata;
    ld_d    = mem_loaddata;
    rv_d    = resv_valid;
    ra_d    = resv_addr;
    stall_c = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (op) begin
          stall_c = 1'b1;
          ctx_d   = ctx_in;
          addr_d  = {mem_ALUout[31:2], 2'b00};
          req_d   = 1'b1;
          we_d    = 4'h0;
          wdata_d = '0;
          state_d = S_ACCESS;
          if (kind_in == K_SC) begin
            if (hit) begin
              we_d    = 4'hF;
              wdata_d = mem_storedata;
            end else begin
              req_d   = 1'b0;
              ld_d    = 32'd1;
              rv_d    = 1'b0;
              state_d = S_DONE;
            end
          end else if (kind_in == K_STORE) begin
            we_d    = mem_dm_write;
            wdata_d = st_rep(mem_storedata,
                             st_size(mem_dm_write));
          end
        end
      end
      S_ACCESS: begin
        stall_c = 1'b1;
        if (dc_ack) begin
          req_d   = 1'b0;
          we_d    = 4'h0;
          state_d = S_DONE;
          unique case (ctx.kind)
            K_LOAD: ld_d = ld_align(dc_rdata,
                                    ctx.off,
                                    ctx.sel);
            K_LR: begin
              ld_d = dc_rdata;
              rv_d = (RESV_EN != 0);
              ra_d = ctx.word;
            end
            K_STORE: begin
              ld_d = '0;
              if (ctx.word == resv_addr)
                rv_d = 1'b0;
            end
            K_SC: begin
              ld_d = '0;
              rv_d = 1'b0;
            end
            K_AMO: begin
              ld_d    = dc_rdata;
              req_d   = 1'b1;
              we_d    = 4'hF;
              wdata_d = amo_res;
              state_d = S_AMO_WR;
            end
            default: ld_d = dc_rdata;
          endcase
        end
      end
      S_AMO_WR: begin
        stall_c = 1'b1;
        if (dc_ack) begin
          req_d   = 1'b0;
          we_d    = 4'h0;
          state_d = S_DONE;
          if (ctx.word == resv_addr)
            rv_d = 1'b0;
        end
      end
      S_DONE: begin
        req_d   = 1'b0;
        we_d    = 4'h0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state and registered cache/result outputs
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state        <= S_IDLE;
      ctx          <= '0;
      dc_req       <= 1'b0;
      dc_we        <= 4'h0;
      dc_addr      <= '0;
      dc_wdata     <= '0;
      mem_loaddata <= '0;
      resv_valid   <= 1'b0;
      resv_addr    <= '0;
    end else begin
      state        <= state_d;
      ctx          <= ctx_d;
      dc_req       <= req_d;
      dc_we        <= we_d;
      dc_addr      <= addr_d;
      dc_wdata     <= wdata_d;
      mem_loaddata <= ld_d;
      resv_valid   <= rv_d;
      resv_addr    <= ra_d;
    end
  end

endmodule
